// File: rtl/keccak_pad_pkg.sv
// Shared keccak constants, pad bytes and padder state encoding.
// Build option: KECCAK_PAD_SHA3_EN selects the SHA-3 domain-separation first pad byte.
package pkg_keccak;

  localparam int IN_BUF_SIZE = 64;
  localparam int RATE_WORDS  = 1024 / IN_BUF_SIZE;

`ifdef KECCAK_PAD_SHA3_EN
  localparam logic [7:0] KECCAK_PAD_FIRST = 8'h06;
`else
  localparam logic [7:0] KECCAK_PAD_FIRST = 8'h01;
`endif
  localparam logic [7:0] KECCAK_PAD_LAST  = 8'h80;

  typedef enum logic [2:0] {
    PS_IDLE, PS_START, PS_DATA, PS_PAD, PS_BLK_WAIT, PS_LAST
  } pad_state_t;

endpackage

// File: rtl/keccak_pad_if.sv
// Message stream into the padder: data word, last/byte-count qualifiers and ready.
interface keccak_pad_if #(parameter int W = 64);

    logic [W-1:0] S_data;
    logic         S_valid;
    logic         S_last;
    logic [3:0]   S_bytes;
    logic         S_ready;

    modport master (output S_data, S_valid, S_last, S_bytes, input  S_ready);
    modport slave  (input  S_data, S_valid, S_last, S_bytes, output S_ready);

endinterface

// File: rtl/keccak_pad_word.sv
// Builds one rate word: keeps the first n bytes, optionally adds the first pad
// byte at position n and the final pad bit in the top byte.
module keccak_pad_word
    import pkg_keccak::*;
#(
    parameter int W = IN_BUF_SIZE
) (
    input  logic [W-1:0] data_i,
    input  logic [3:0]   n_i,
    input  logic         pad_first_i,
    input  logic         is_word15_i,
    output logic [W-1:0] word_o
);

    localparam int NB = W / 8;

    // NOTE: word_o gets a full default first so no path through this block can infer a latch.
    always_comb begin
        word_o = '0;
        for (int k = 0; k < NB; k++) begin
            if (k < int'(n_i))
                word_o[8*k +: 8] = data_i[8*k +: 8];
            if (pad_first_i && (k == int'(n_i)))
                word_o[8*k +: 8] = word_o[8*k +: 8] | KECCAK_PAD_FIRST;
        end
        if (is_word15_i)
            word_o[W-1 -: 8] = word_o[W-1 -: 8] | KECCAK_PAD_LAST;
    end

endmodule

// File: rtl/keccak_pad.sv
// pad10*1 message padder and word sequencer feeding the keccak core.
// Build option: KECCAK_PAD_SHA3_EN (see pkg_keccak) changes the first pad byte.
module keccak_pad
    import pkg_keccak::*;
#(
    parameter int W          = IN_BUF_SIZE,
    parameter int RATE_WORDS = pkg_keccak::RATE_WORDS
) (
    input  logic          Clock,
    input  logic          Reset,
    keccak_pad_if.slave   s_if,
    input  logic          Core_buffer_full,
    input  logic          Core_ready,
    output logic          Start,
    output logic [W-1:0]  Din,
    output logic          Din_valid,
    output logic          Last_block,
    output logic          Busy
);

    localparam logic [2:0] ST_IDLE     = PS_IDLE;
    localparam logic [2:0] ST_START    = PS_START;
    localparam logic [2:0] ST_DATA     = PS_DATA;
    localparam logic [2:0] ST_PAD      = PS_PAD;
    localparam logic [2:0] ST_BLK_WAIT = PS_BLK_WAIT;
    localparam logic [2:0] ST_LAST     = PS_LAST;
    localparam logic [3:0] WC_LAST     = 4'(RATE_WORDS - 1);

    logic [2:0]   state_q, state_d;
    logic [3:0]   wc_q, wc_d;
    logic         pad_first_q, pad_first_d;
    logic         final_q, final_d;
    logic         seen_full_q, seen_full_d;
    logic         start_q, start_d;
    logic [W-1:0] din_q, din_d;
    logic         din_valid_q, din_valid_d;
    logic         last_block_q, last_block_d;
    logic         busy_q, busy_d;

    logic [3:0]   n_clamp;
    logic         tail, xfer, in_pad;
    logic [W-1:0] w_data, w_word;
    logic [3:0]   w_n;
    logic         w_pf, w_15;

    assign s_if.S_ready = (state_q == ST_DATA) && !Core_buffer_full;
    assign xfer         = s_if.S_valid && s_if.S_ready;
    assign n_clamp      = (s_if.S_bytes > 4'd8) ? 4'd8 : s_if.S_bytes;
    // A partial (or empty) final word carries the first pad byte itself.
    assign tail         = s_if.S_last && (n_clamp != 4'd8);

    // Generated pad words reuse the data path with an empty, all-zero input.
    assign in_pad = (state_q == ST_PAD);
    assign w_data = in_pad ? '0 : s_if.S_data;
    assign w_n    = in_pad ? 4'd0 : (s_if.S_last ? n_clamp : 4'd8);
    assign w_pf   = in_pad ? pad_first_q : tail;
    assign w_15   = (wc_q == WC_LAST) && (in_pad || tail);

    keccak_pad_word #(.W(W)) u_word (
        .data_i      (w_data),
        .n_i         (w_n),
        .pad_first_i (w_pf),
        .is_word15_i (w_15),
        .word_o      (w_word)
    );

    always_comb begin
        state_d      = state_q;
        wc_d         = wc_q;
        pad_first_d  = pad_first_q;
        final_d      = final_q;
        seen_full_d  = seen_full_q;
        start_d      = 1'b0;
        din_d        = din_q;
        din_valid_d  = 1'b0;
        last_block_d = 1'b0;
        busy_d       = busy_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (s_if.S_valid) state_d = ST_START;
            end
            ST_START: begin
                start_d     = 1'b1;
                busy_d      = 1'b1;
                wc_d        = '0;
                pad_first_d = 1'b0;
                final_d     = 1'b0;
                seen_full_d = 1'b0;
                state_d     = ST_DATA;
            end
            ST_DATA: begin
                if (xfer) begin
                    din_d       = w_word;
                    din_valid_d = 1'b1;
                    wc_d        = wc_q + 4'd1;
                    if (s_if.S_last) begin
                        if (!tail) pad_first_d = 1'b1;
                        if (wc_q == WC_LAST) begin
                            final_d = tail;
                            state_d = ST_BLK_WAIT;
                        end else begin
                            state_d = ST_PAD;
                        end
                    end else if (wc_q == WC_LAST) begin
                        state_d = ST_BLK_WAIT;
                    end
                end
            end
            ST_PAD: begin
                if (!Core_buffer_full) begin
                    din_d       = w_word;
                    din_valid_d = 1'b1;
                    wc_d        = wc_q + 4'd1;
                    pad_first_d = 1'b0;
                    if (wc_q == WC_LAST) begin
                        final_d = 1'b1;
                        state_d = ST_BLK_WAIT;
                    end
                end
            end
            ST_BLK_WAIT: begin
                // The block is absorbed only once the core has raised and then dropped Buffer_full.
                if (Core_buffer_full) seen_full_d = 1'b1;
                if (seen_full_q && !Core_buffer_full) begin
                    seen_full_d = 1'b0;
                    if (final_q)          state_d = ST_LAST;
                    else if (pad_first_q) state_d = ST_PAD;
                    else                  state_d = ST_DATA;
                end
            end
            ST_LAST: begin
                if (Core_ready) begin
                    last_block_d = 1'b1;
                    final_d      = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            wc_q         <= '0;
            pad_first_q  <= 1'b0;
            final_q      <= 1'b0;
            seen_full_q  <= 1'b0;
            start_q      <= 1'b0;
            din_q        <= '0;
            din_valid_q  <= 1'b0;
            last_block_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wc_q         <= wc_d;
            pad_first_q  <= pad_first_d;
            final_q      <= final_d;
            seen_full_q  <= seen_full_d;
            start_q      <= start_d;
            din_q        <= din_d;
            din_valid_q  <= din_valid_d;
            last_block_q <= last_block_d;
            busy_q       <= busy_d;
        end
    end

    assign Start      = start_q;
    assign Din        = din_q;
    assign Din_valid  = din_valid_q;
    assign Last_block = last_block_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_keccak_pad.sv
// Directed bench for keccak_pad with a behavioural core model and a pad10*1 reference.
module tb_keccak_pad;

`ifdef KECCAK_PAD_SHA3_EN
    localparam logic [7:0] P0 = 8'h06;
`else
    localparam logic [7:0] P0 = 8'h01;
`endif
    localparam logic [7:0] P1 = 8'h80;
    localparam int BUDGET = 3000;

    typedef struct {
        int len;
        int hold;
        bit big;
        int blocks;
    } vec_t;

    logic        Clock;
    logic        Reset;
    logic        Core_buffer_full = 1'b0;
    logic        Core_ready = 1'b0;
    logic        Start, Din_valid, Last_block, Busy;
    logic [63:0] Din;

    keccak_pad_if #(.W(64)) s_if ();

    keccak_pad dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .s_if             (s_if),
        .Core_buffer_full (Core_buffer_full),
        .Core_ready       (Core_ready),
        .Start            (Start),
        .Din              (Din),
        .Din_valid        (Din_valid),
        .Last_block       (Last_block),
        .Busy             (Busy)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] msg_byte(input int i);
        logic [7:0] b;
        b = 8'hAA + 8'(i * 17);
        return b;
    endfunction

    function automatic logic [63:0] exp_word(input int len, input int j);
        int total_bytes;
        int idx;
        logic [7:0]  b;
        logic [63:0] w;
        total_bytes = (len / 128 + 1) * 128;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            idx = 8 * j + k;
            b = (idx < len) ? msg_byte(idx) : 8'h00;
            if (idx == len) b = b | P0;
            if (idx == total_bytes - 1) b = b | P1;
            w[8*k +: 8] = b;
        end
        return w;
    endfunction

    // Core model: absorbs 16 words, then holds Buffer_full for 'hold' cycles.
    logic [63:0] log_q[$];
    int hold = 3;
    int cw = 0, full_cnt = 0;
    int start_cnt = 0, last_cnt = 0, viol = 0, words_at_last = 0;
    logic busy_at_last = 1'b0;
    logic prev_full = 1'b0;

    always @(negedge Clock) begin
        if (Reset) begin
            cw = 0;
            full_cnt = 0;
            prev_full = 1'b0;
            Core_buffer_full = 1'b0;
            Core_ready = 1'b0;
        end else begin
            if (Core_buffer_full && s_if.S_ready) viol++;
            if (prev_full && Din_valid) viol++;
            if (Start) begin
                start_cnt++;
                cw = 0;
            end
            if (Last_block) begin
                last_cnt++;
                words_at_last = log_q.size();
                busy_at_last = Busy;
                if (Din_valid) viol++;
            end
            if (Din_valid) begin
                log_q.push_back(Din);
                cw++;
                if (cw == 16) begin
                    cw = 0;
                    full_cnt = hold;
                end
            end
            prev_full = Core_buffer_full;
            if (full_cnt > 0) begin
                Core_buffer_full = 1'b1;
                full_cnt--;
            end else begin
                Core_buffer_full = 1'b0;
            end
            Core_ready = ~Core_buffer_full;
        end
    end

    task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
        int t;
        s_if.S_data  = d;
        s_if.S_valid = 1'b1;
        s_if.S_last  = last;
        s_if.S_bytes = nb;
        t = 0;
        #1;
        while (!s_if.S_ready && t < BUDGET) begin
            @(negedge Clock);
            #1;
            t++;
        end
        if (t >= BUDGET) check("send_timeout", 64'(s_if.S_ready), 64'd1);
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic run_msg(input vec_t v, input int id);
        int base_w, base_s, base_l, base_v, nwords, nb, t, exp_n;
        logic [63:0] d;
        hold   = v.hold;
        base_w = log_q.size();
        base_s = start_cnt;
        base_l = last_cnt;
        base_v = viol;
        nwords = (v.len == 0) ? 1 : (v.len + 7) / 8;
        exp_n  = v.blocks * 16;
        for (int w = 0; w < nwords; w++) begin
            for (int k = 0; k < 8; k++)
                d[8*k +: 8] = (8*w + k < v.len) ? msg_byte(8*w + k) : 8'hEE;
            nb = (w == nwords - 1) ? v.len - 8*w : 8;
            if (w == nwords - 1 && v.big && nb == 8) nb = 12;
            send_word(d, w == nwords - 1, 4'(nb));
        end
        s_if.S_valid = 1'b0;
        s_if.S_last  = 1'b0;
        t = 0;
        while (last_cnt == base_l && t < BUDGET) begin
            @(negedge Clock);
            t++;
        end
        check($sformatf("v%0d_lb_timeout", id), 64'(t < BUDGET), 64'd1);
        repeat (6) @(negedge Clock);
        check($sformatf("v%0d_words", id), 64'(log_q.size() - base_w), 64'(exp_n));
        check($sformatf("v%0d_words_at_last", id), 64'(words_at_last - base_w), 64'(exp_n));
        check($sformatf("v%0d_starts", id), 64'(start_cnt - base_s), 64'd1);
        check($sformatf("v%0d_lasts", id), 64'(last_cnt - base_l), 64'd1);
        check($sformatf("v%0d_protocol", id), 64'(viol - base_v), 64'd0);
        check($sformatf("v%0d_busy_at_last", id), 64'(busy_at_last), 64'd1);
        check($sformatf("v%0d_busy_end", id), 64'(Busy), 64'd0);
        if (log_q.size() - base_w == exp_n)
            for (int j = 0; j < exp_n; j++)
                check($sformatf("v%0d_w%0d", id, j), log_q[base_w + j], exp_word(v.len, j));
    endtask

    vec_t vecs [9];

    initial begin
        vecs[0] = '{len: 0,   hold: 3,  big: 1'b0, blocks: 1};
        vecs[1] = '{len: 3,   hold: 3,  big: 1'b0, blocks: 1};
        vecs[2] = '{len: 127, hold: 3,  big: 1'b0, blocks: 1};
        vecs[3] = '{len: 128, hold: 3,  big: 1'b0, blocks: 2};
        vecs[4] = '{len: 8,   hold: 3,  big: 1'b0, blocks: 1};
        vecs[5] = '{len: 120, hold: 3,  big: 1'b0, blocks: 1};
        vecs[6] = '{len: 200, hold: 20, big: 1'b0, blocks: 2};
        vecs[7] = '{len: 16,  hold: 3,  big: 1'b1, blocks: 1};
        vecs[8] = '{len: 256, hold: 3,  big: 1'b0, blocks: 3};

        Reset        = 1'b1;
        s_if.S_data  = '0;
        s_if.S_valid = 1'b0;
        s_if.S_last  = 1'b0;
        s_if.S_bytes = '0;
        repeat (3) @(negedge Clock);
        check("rst_ctrl", 64'({Start, Din_valid, Last_block, Busy, s_if.S_ready}), 64'd0);
        check("rst_din", Din, 64'd0);
        Reset = 1'b0;
        @(negedge Clock);

        for (int i = 0; i < 9; i++) run_msg(vecs[i], i);

        // Hand-computed anchors for the empty, 3-byte and 127-byte messages.
        begin
            vec_t e;
            int b;
            e = '{len: 0, hold: 3, big: 1'b0, blocks: 1};
            b = log_q.size();
            run_msg(e, 90);
            check("empty_w0", log_q[b], {56'd0, P0});
            check("empty_w15", log_q[b + 15], 64'h8000000000000000);
            e = '{len: 3, hold: 3, big: 1'b0, blocks: 1};
            b = log_q.size();
            run_msg(e, 91);
            check("three_w0", log_q[b], {32'd0, P0, 24'hCCBBAA});
            e = '{len: 127, hold: 3, big: 1'b0, blocks: 1};
            b = log_q.size();
            run_msg(e, 92);
            check("b127_top", 64'(log_q[b + 15][63:56]), 64'(P0 | P1));
        end

        // Reset in the middle of a block, then a fresh message.
        begin
            logic [63:0] d;
            hold = 3;
            for (int w = 0; w < 6; w++) begin
                for (int k = 0; k < 8; k++) d[8*k +: 8] = msg_byte(8*w + k);
                send_word(d, 1'b0, 4'd8);
            end
            check("mid_busy", 64'(Busy), 64'd1);
            check("mid_valid", 64'(Din_valid), 64'd1);
            Reset = 1'b1;
            s_if.S_valid = 1'b0;
            #1;
            check("mid_rst_ctrl", 64'({Start, Din_valid, Last_block, Busy, s_if.S_ready}), 64'd0);
            check("mid_rst_din", Din, 64'd0);
            @(negedge Clock);
            @(negedge Clock);
            Reset = 1'b0;
            @(negedge Clock);
            run_msg(vecs[1], 99);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keccak_pad.md
Name: keccak_pad

Overview:
- Message padder and word sequencer sitting directly upstream of the keccak core.
- Accepts an arbitrary-length byte message as a stream of 64-bit words on a valid/ready interface.
- Applies Keccak pad10*1 padding on the 1024-bit rate and drives the core's Start, Din, Din_valid and Last_block inputs.
- Throttles on the core's Buffer_full and Ready outputs so no word is dropped while a block is being absorbed.

Parameters:
W, 64, word width; equals pkg_keccak::IN_BUF_SIZE.
RATE_WORDS, 16, words per rate block (1024/W).

Ports:
Clock  in  1  clock; all logic on rising edge.
Reset  in  1  asynchronous, active-high reset.
S_data  in  W  message word; byte k occupies bits [8k+7:8k].
S_valid  in  1  S_data valid.
S_last  in  1  final word of message; qualifies S_bytes.
S_bytes  in  4  valid bytes in the final word, 0..8; 0 means no data bytes (empty tail). Ignored unless S_last.
S_ready  out  1  padder accepts S_data this cycle.
Core_buffer_full  in  1  core Buffer_full.
Core_ready  in  1  core Ready (permutation computed).
Start  out  1  one-cycle pulse that clears the core.
Din  out  W  word to core.
Din_valid  out  1  Din valid; one word per cycle.
Last_block  out  1  one-cycle pulse after the final block is absorbed; Din_valid is low in that cycle.
Busy  out  1  high from message acceptance until Last_block is issued.

Behaviour:
- Reset values: all outputs 0; state IDLE; word counter wc = 0; flags cleared.
- Din, Din_valid, Start and Last_block are registered. A transfer is S_valid & S_ready; it is presented on Din one cycle later.
- Bytes beyond S_bytes in the final word are masked to zero before padding is ORed in.
- Pad constants: P0 = 0x01 (first pad byte); P1 = 0x80 (ORed into byte 7 of word RATE_WORDS-1 of the final block).
- State machine:
  - IDLE: S_ready = 0. S_valid moves to START.
  - START: Start = 1 for one cycle; wc = 0; Busy = 1. Next state DATA.
  - DATA: S_ready = ~Core_buffer_full.
    - Each transfer increments wc (4-bit, wraps at 16).
    - Non-last word with wc == 15: enter BLK_WAIT.
    - Last word with n = S_bytes < 8: byte n = P0. If wc == 15, byte 7 |= P1 (n = 7 gives 0x81 in byte 7) and go to BLK_WAIT with final flag set; otherwise go to PAD.
    - Last word with n == 8: word is passed unmodified. Set pad_first. Go to BLK_WAIT if wc == 15, else PAD. The final flag is not set in either case.
  - PAD: S_ready = 0. While ~Core_buffer_full, emit one generated word per cycle:
    - base word is zero;
    - byte 0 = P0 if pad_first (then clear pad_first);
    - byte 7 |= P1 if wc == 15.
    - After wc == 15 is emitted, set final and go to BLK_WAIT.
  - BLK_WAIT: nothing is issued.
    - Latch seen_full when Core_buffer_full = 1.
    - Leave when seen_full & ~Core_buffer_full: go to LAST if final, else PAD if pad_first, else DATA.
    - Clear seen_full on exit.
  - LAST: wait for Core_ready = 1, then Last_block = 1 for one cycle. Busy falls the following cycle. Next state IDLE.
- An empty message (first word S_last, S_bytes = 0) produces exactly one block: word0 = 0x01, word15 = 0x8000000000000000.
- A message whose length is a multiple of 128 bytes produces an extra full pad block.
- An S_bytes value > 8 is treated as 8.
- S_valid and S_last arriving in IDLE are held off by S_ready = 0 until DATA.
- Reset mid-message: immediate return to IDLE, all outputs cleared. No Last_block is issued.

Optional Feature:
- Macro KECCAK_PAD_SHA3_EN.
- Defined: P0 = 0x06 (SHA-3 domain separation). Empty-message word0 = 0x06; P0 = 0x06 also applies on the n = 7, wc == 15 case, giving byte 7 = 0x86.
- Undefined: P0 = 0x01 (original Keccak padding).
- P1 is 0x80 in both cases.

Decomposition:
- pkg_keccak gains RATE_WORDS, the pad constants (KECCAK_PAD_FIRST / KECCAK_PAD_LAST) and a pad_state_t enum.
- The W constant is reused from IN_BUF_SIZE.
- One sub-module: keccak_pad_word, a combinational block that builds the output word from (data, n, pad_first, is_word15). It is shared by the DATA and PAD paths.

Test Plan:
1. Empty message (S_last, S_bytes = 0) -> 16 Din words: word0 = 0x01, words 1-14 = 0, word15 = 0x8000000000000000; then Last_block once Core_ready = 1.
2. 3-byte message 0xCCBBAA -> word0 = 0x01CCBBAA, word15 = 0x8000000000000000; exactly 16 Din_valid pulses.
3. 127-byte message (wc = 15, n = 7) -> word15 byte 7 = 0x81; single block; no extra block.
4. 128-byte message -> 32 Din words: second block word0 = 0x01, word15 = 0x8000000000000000.
5. Hold Core_buffer_full = 1 for 20 cycles after word 15 -> no Din_valid and S_ready = 0 throughout; streaming resumes after the fall.
6. Reset asserted at word 5 of a block -> outputs 0 next edge; a new message then starts with a fresh Start pulse. With KECCAK_PAD_SHA3_EN, case 1 gives word0 = 0x06.
